multicycle_sequencer: RTL and testbench

//  Parametrised multicycle control sequencer for the 9-bit-ISA core. Owns the PC, instruction register,

---
 rtl/core_pkg.sv | 38 +++
 rtl/seq_mem_timer.sv | 31 +++
 rtl/multicycle_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 9-bit-ISA core: sequencer states, opcode map
// and opcode classification helpers used by the sequencer, ALU and lookup.
package core_pkg;

    localparam int OP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_HALT  = '1;
    localparam logic [OP_W-1:0] OP_BR    = 4'hE;
    localparam logic [OP_W-1:0] OP_STORE = 4'hD;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'hC;

    // One bit per opcode: set where the ALU result updates the carry flag
    // (opcodes 0..3: add/sub family).
    localparam logic [2**OP_W-1:0] CARRY_OPS = 16'h000F;

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_br(input logic [OP_W-1:0] op);
        return op == OP_BR;
    endfunction

    function automatic logic is_carry_op(input logic [OP_W-1:0] op);
        return CARRY_OPS[op];
    endfunction

endpackage

// File: rtl/seq_mem_timer.sv
// Data-memory wait timer: down-counter reloaded whenever the sequencer is
// outside MEM, so every MEM visit starts with a full MEM_TMO-cycle budget.
module seq_mem_timer #(
    parameter int MEM_TMO = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tmo
);

    localparam int TW = $clog2(MEM_TMO + 1);
    localparam logic [TW-1:0] RELOAD = TW'(MEM_TMO - 1);

    logic [TW-1:0] cnt_q;

    // Count down while waiting in MEM; reload otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RELOAD;
        end else if (!run) begin
            cnt_q <= RELOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Terminal count: this is the MEM_TMO-th MEM cycle without ready.
    assign tmo = run && (cnt_q == '0);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: PC, instruction register, carry flag,
// done/error status and saturating cycle counter.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | after reset, waiting for start_i
//   ST_FETCH  | ROM data at pc_o captured into ir_o
//   ST_DECODE | lookup / reg_file read settle
//   ST_EXEC   | carry update, branch resolve, dispatch
//   ST_MEM    | dm_req_o held until dm_ready_i or timeout
//   ST_WB     | rf_we_o pulse, PC advance
//   ST_HALT   | outputs frozen, done_o (and maybe err_o) held
module multicycle_sequencer
    import core_pkg::*;
#(
    parameter int IW       = 9,
    parameter int OPW      = 4,
    parameter int PCW      = 8,
    parameter int PROG_LEN = 256,
    parameter int MEM_TMO  = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    output logic [PCW-1:0]   pc_o,
    input  logic [IW-1:0]    instr_i,
    output logic [IW-1:0]    ir_o,
    input  logic             br_taken_i,
    input  logic [PCW-1:0]   br_target_i,
    input  logic             alu_ov_i,
    output logic             carry_o,
    output logic             dm_req_o,
    output logic             dm_we_o,
    input  logic             dm_ready_i,
    output logic             rf_we_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cycles_o
);

    state_t           state_q, state_d, adv_state;
    logic [PCW-1:0]   pc_q, pc_d, adv_pc;
    logic [IW-1:0]    ir_q, ir_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cyc_q;
    logic [OPW-1:0]   op;
    logic [PCW:0]     pc_inc;
    logic             pc_end, tgt_oob, mem_tmo, running;

    assign op      = ir_q[IW-1 -: OPW];
    // One extra bit so PROG_LEN == 2**PCW is representable; no wrap is ever taken.
    assign pc_inc  = {1'b0, pc_q} + (PCW+1)'(1);
    assign pc_end  = (pc_inc == (PCW+1)'(PROG_LEN));
    assign tgt_oob = ({1'b0, br_target_i} >= (PCW+1)'(PROG_LEN));
    assign running = (state_q != ST_IDLE) && (state_q != ST_HALT);

    // Sequential PC advance: halt in place when the next PC would leave the program.
    assign adv_state = pc_end ? ST_HALT : ST_FETCH;
    assign adv_pc    = pc_end ? pc_q : pc_inc[PCW-1:0];

    seq_mem_timer #(
        .MEM_TMO (MEM_TMO)
    ) u_mem_timer (
        .clk   (clk),
        .reset (reset),
        .run   (state_q == ST_MEM),
        .tmo   (mem_tmo)
    );

    // Next-state, PC, IR, carry and status decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    carry_d = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = instr_i;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_carry_op(op)) carry_d = alu_ov_i;
                if (op == OP_HALT) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                end else if (is_br(op)) begin
                    if (!br_taken_i) begin
                        state_d = adv_state;
                        pc_d    = adv_pc;
                        done_d  = pc_end;
                    end else if (tgt_oob) begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = br_target_i;
                    end
                end else if (is_mem(op)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dm_ready_i) begin
                    if (op == OP_STORE) begin
                        state_d = adv_state;
                        pc_d    = adv_pc;
                        done_d  = pc_end;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (mem_tmo) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_WB: begin
                state_d = adv_state;
                pc_d    = adv_pc;
                done_d  = pc_end;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Saturating run-cycle counter, cleared by an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
        end else if (start_i && !running) begin
            cyc_q <= '0;
        end else if (running && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign dm_req_o = (state_q == ST_MEM);
    assign dm_we_o  = (state_q == ST_MEM) && (op == OP_STORE);
    assign rf_we_o  = (state_q == ST_WB);
    assign pc_o     = pc_q;
    assign ir_o     = ir_q;
    assign carry_o  = carry_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign cycles_o = cyc_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed programs plus random programs,
// each checked against a per-instruction cost model of the sequencer.
module tb_multicycle_sequencer;

    localparam int IW       = 9;
    localparam int OPW      = 4;
    localparam int PCW      = 8;
    localparam int PROG_LEN = 20;
    localparam int MEM_TMO  = 15;
    localparam int CNT_W    = 6;
    localparam int CMAX     = 2**CNT_W - 1;

    localparam int O_ADD = 0, O_OR = 6, O_LD = 12, O_ST = 13, O_BR = 14, O_HLT = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start_i = 1'b0;
    logic [PCW-1:0]   pc_o;
    logic [IW-1:0]    instr_i;
    logic [IW-1:0]    ir_o;
    logic             br_taken_i;
    logic [PCW-1:0]   br_target_i;
    logic             alu_ov_i;
    logic             carry_o;
    logic             dm_req_o;
    logic             dm_we_o;
    logic             dm_ready_i;
    logic             rf_we_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] cycles_o;

    logic [IW-1:0]  rom   [0:255];
    logic           br_tk [0:255];
    logic [PCW-1:0] br_tg [0:255];
    logic           ov    [0:255];
    int             wt    [0:255];
    logic           stray = 1'b0;
    int             mem_cnt = 0;
    int             n_assert = 0;
    int             n_fail = 0;

    typedef struct {
        int pc; int cyc; int err; int carry; int rfw; int memc; int wec; int first_rf;
    } exp_t;

    multicycle_sequencer #(
        .IW(IW), .OPW(OPW), .PCW(PCW), .PROG_LEN(PROG_LEN), .MEM_TMO(MEM_TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .pc_o(pc_o), .instr_i(instr_i),
        .ir_o(ir_o), .br_taken_i(br_taken_i), .br_target_i(br_target_i), .alu_ov_i(alu_ov_i),
        .carry_o(carry_o), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_ready_i(dm_ready_i),
        .rf_we_o(rf_we_o), .done_o(done_o), .err_o(err_o), .cycles_o(cycles_o)
    );

    always #5 clk = ~clk;

    // ROM / lookup / ALU side-band indexed by the current PC; memory answers
    // after wt[pc] waiting cycles, stray drives ready outside MEM.
    assign instr_i     = rom[pc_o];
    assign br_taken_i  = br_tk[pc_o];
    assign br_target_i = br_tg[pc_o];
    assign alu_ov_i    = ov[pc_o];
    assign dm_ready_i  = dm_req_o ? (mem_cnt == wt[pc_o]) : stray;

    always @(posedge clk) mem_cnt <= dm_req_o ? mem_cnt + 1 : 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input int op);
        logic [4:0] lo;
        logic [3:0] o;
        lo = 5'($urandom);
        o  = op[3:0];
        return {o, lo};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            rom[i] = mk(O_HLT); br_tk[i] = 1'b0; br_tg[i] = '0; ov[i] = 1'b0; wt[i] = 0;
        end
    endtask

    // Walks the program instruction by instruction, accumulating the cost of
    // each class: ALU 4, branch 3, halt 3, store 4+w, load 5+w, timeout 3+MEM_TMO.
    function automatic exp_t model();
        exp_t e;
        int pc, op;
        e = '{pc:0, cyc:0, err:0, carry:0, rfw:0, memc:0, wec:0, first_rf:-1};
        pc = 0;
        for (int s = 0; s < 400; s++) begin
            op = int'(rom[pc][IW-1 -: OPW]);
            if (op == O_HLT) begin e.cyc += 3; break; end
            if (op < 4) e.carry = int'(ov[pc]);
            if (op == O_BR) begin
                e.cyc += 3;
                if (br_tk[pc]) begin
                    if (int'(br_tg[pc]) >= PROG_LEN) break;
                    pc = int'(br_tg[pc]);
                    continue;
                end
            end else if (op == O_LD || op == O_ST) begin
                if (wt[pc] >= MEM_TMO) begin
                    e.cyc += 3 + MEM_TMO; e.memc += MEM_TMO; e.err = 1;
                    if (op == O_ST) e.wec += MEM_TMO;
                    break;
                end
                e.memc += wt[pc] + 1;
                if (op == O_ST) begin
                    e.cyc += 4 + wt[pc]; e.wec += wt[pc] + 1;
                end else begin
                    e.cyc += 5 + wt[pc]; e.rfw++;
                    if (e.first_rf < 0) e.first_rf = e.cyc;
                end
            end else begin
                e.cyc += 4; e.rfw++;
                if (e.first_rf < 0) e.first_rf = e.cyc;
            end
            if (pc + 1 == PROG_LEN) break;
            pc++;
        end
        e.pc = pc;
        return e;
    endfunction

    task automatic run(input string tag, input bit mid_start);
        exp_t e;
        int n, rfw, memc, wec, first_rf;
        bit got;
        e = model();
        n = 0; rfw = 0; memc = 0; wec = 0; first_rf = -1; got = 0;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        chk({tag, "_start_done"},  int'(done_o), 0);
        chk({tag, "_start_err"},   int'(err_o), 0);
        chk({tag, "_start_pc"},    int'(pc_o), 0);
        chk({tag, "_start_carry"}, int'(carry_o), 0);
        chk({tag, "_start_cyc"},   int'(cycles_o), 0);
        while (!got && n < 1000) begin
            start_i = (mid_start && n == 2);
            @(posedge clk); #1; n++;
            if (rf_we_o) begin rfw++; if (first_rf < 0) first_rf = n + 1; end
            if (dm_req_o) memc++;
            if (dm_we_o) wec++;
            if (done_o) got = 1;
        end
        start_i = 1'b0;
        chk({tag, "_done"},     int'(got), 1);
        chk({tag, "_latency"},  n, e.cyc);
        chk({tag, "_err"},      int'(err_o), e.err);
        chk({tag, "_pc"},       int'(pc_o), e.pc);
        chk({tag, "_ir"},       int'(ir_o), int'(rom[e.pc]));
        chk({tag, "_cycles"},   int'(cycles_o), (e.cyc > CMAX) ? CMAX : e.cyc);
        chk({tag, "_carry"},    int'(carry_o), e.carry);
        chk({tag, "_rf_we"},    rfw, e.rfw);
        chk({tag, "_first_rf"}, first_rf, e.first_rf);
        chk({tag, "_dm_req"},   memc, e.memc);
        chk({tag, "_dm_we"},    wec, e.wec);
    endtask

    initial begin
        int r, op, k;
        clear_prog();

        // Reset state
        #2;
        chk("rst_pc", int'(pc_o), 0);       chk("rst_ir", int'(ir_o), 0);
        chk("rst_carry", int'(carry_o), 0); chk("rst_req", int'(dm_req_o), 0);
        chk("rst_rfwe", int'(rf_we_o), 0);  chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);     chk("rst_cyc", int'(cycles_o), 0);
        @(negedge clk); reset = 1'b1;

        // IDLE holds without start, stray ready ignored
        stray = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("idle_pc", int'(pc_o), 0); chk("idle_cyc", int'(cycles_o), 0);
        chk("idle_rfwe", int'(rf_we_o), 0); chk("idle_done", int'(done_o), 0);
        stray = 1'b0;

        // ADD, ADD, HALT with a start pulse while running
        rom[0] = mk(O_ADD); rom[1] = mk(O_ADD); rom[2] = mk(O_HLT);
        ov[0] = 1'b1; ov[1] = 1'b0;
        run("add_add_halt", 1'b1);

        // Branch at PC=3: taken in range, not taken, taken to PROG_LEN
        clear_prog();
        for (int i = 0; i < 3; i++) rom[i] = mk(O_OR);
        rom[3] = mk(O_BR); rom[4] = mk(O_HLT); rom[16] = mk(O_HLT);
        br_tk[3] = 1'b1; br_tg[3] = 8'h10;
        run("br_taken", 1'b0);
        br_tk[3] = 1'b0;
        run("br_not_taken", 1'b0);
        br_tk[3] = 1'b1; br_tg[3] = 8'(PROG_LEN);
        run("br_oob", 1'b0);

        // Load with ready after 3 waits, stray ready outside MEM
        clear_prog();
        rom[0] = mk(O_LD); wt[0] = 3;
        stray = 1'b1;
        run("load_w3", 1'b0);
        stray = 1'b0;

        // Store: last-chance ready, then no ready at all (timeout)
        rom[0] = mk(O_ST); wt[0] = MEM_TMO - 1;
        run("store_w14", 1'b0);
        wt[0] = 255;
        run("store_tmo", 1'b0);

        // Program-length termination with carry tracking only on carry ops
        clear_prog();
        for (int i = 0; i < PROG_LEN; i++) begin
            if (i % 2 == 0) begin rom[i] = mk(1); ov[i] = 1'($urandom); end
            else begin rom[i] = mk(O_OR); ov[i] = ~ov[i-1]; end
        end
        run("prog_len", 1'b0);

        // Random programs
        for (int t = 0; t < 14; t++) begin
            clear_prog();
            for (int i = 0; i < PROG_LEN; i++) begin
                r = $urandom_range(99);
                op = (r < 30) ? $urandom_range(3) : (r < 50) ? $urandom_range(11, 4) :
                     (r < 60) ? O_LD : (r < 70) ? O_ST : (r < 85) ? O_BR : O_HLT;
                rom[i]   = mk(op);
                ov[i]    = 1'($urandom);
                br_tk[i] = 1'($urandom);
                br_tg[i] = 8'($urandom_range(PROG_LEN + 2, i + 1));
                wt[i]    = ($urandom_range(9) == 0) ? $urandom_range(16, 14) : $urandom_range(4);
            end
            stray = 1'($urandom);
            run($sformatf("rand%0d", t), 1'($urandom));
        end
        stray = 1'b0;

        // Reset while waiting in MEM
        clear_prog();
        rom[0] = mk(O_ST); wt[0] = 255;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        k = 0;
        while (!dm_req_o && k < 20) begin @(posedge clk); #1; k++; end
        chk("rstmem_reached", int'(dm_req_o), 1);
        @(posedge clk); #3; reset = 1'b0; #1;
        chk("rstmem_req", int'(dm_req_o), 0);  chk("rstmem_we", int'(dm_we_o), 0);
        chk("rstmem_pc", int'(pc_o), 0);       chk("rstmem_ir", int'(ir_o), 0);
        chk("rstmem_done", int'(done_o), 0);   chk("rstmem_err", int'(err_o), 0);
        chk("rstmem_cyc", int'(cycles_o), 0);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rstmem_idle_req", int'(dm_req_o), 0);
        chk("rstmem_idle_cyc", int'(cycles_o), 0);
        rom[0] = mk(O_ADD); rom[1] = mk(O_HLT);
        run("after_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
